// File: rtl/wedge_pkg.sv
// -----------------------------------------------------------------------------
// wedge_pkg
// Shared types and constants for the wedge_drv serial line driver.
//   wedge_cmd_e   : command encoding carried on req_cmd_i
//   wedge_state_e : driver FSM states (ST_PULSE only exists when
//                   WEDGE_DRV_PULSE_EN is defined)
//   CNT_W         : hold counter width, wide enough for HOLD_CYCLES up to 255
//   target_level  : level a level-type command drives the line to
// -----------------------------------------------------------------------------
package wedge_pkg;

    typedef enum logic [1:0] {
        SET_LOW  = 2'd0,
        SET_HIGH = 2'd1,
        TOGGLE   = 2'd2,
        PULSE    = 2'd3
    } wedge_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1
`ifdef WEDGE_DRV_PULSE_EN
        ,
        ST_PULSE = 2'd2
`endif
    } wedge_state_e;

    localparam int CNT_W = $clog2(256);

    // Level requested by a command given the present line level. PULSE
    // starts by flipping the line, so it shares TOGGLE's target.
    function automatic logic target_level(input wedge_cmd_e cmd, input logic cur);
        logic lvl;
        case (cmd)
            SET_LOW:  lvl = 1'b0;
            SET_HIGH: lvl = 1'b1;
            default:  lvl = ~cur;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/wedge_hold_cnt.sv
// -----------------------------------------------------------------------------
// wedge_hold_cnt
// Down-counter that times how long the serial line must stay stable.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset, clears count to 0
//   clr_i     : synchronous clear, same effect as rst_i
//   load_i    : load value_i (takes priority over counting)
//   value_i   : load value
//   enable_i  : decrement by one when the count is non-zero
//   zero_o    : count is zero
// -----------------------------------------------------------------------------
module wedge_hold_cnt
    import wedge_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             enable_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= value_i;
        end else if (enable_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/wedge_drv.sv
// -----------------------------------------------------------------------------
// wedge_drv
// Drives a registered serial line toward a remote synchronising edge
// detector, guaranteeing that consecutive line edges are at least
// HOLD_CYCLES clock cycles apart, and strobes r_edge_o / f_edge_o in the
// first cycle the line shows a new level caused by a command.
//
// Optional feature macro: WEDGE_DRV_PULSE_EN
//   defined   : PULSE flips the line for HOLD_CYCLES cycles, then flips back
//   undefined : an accepted PULSE is consumed as a no-op
//
// Parameters:
//   HOLD_CYCLES : minimum stable cycles after any edge (1..255)
//   RESET_VAL   : line level after reset or clear
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   clr_i        : synchronous clear, aborts the current operation
//   en_i         : advance enable; low freezes state, counter and line
//   req_valid_i  : command valid
//   req_cmd_i    : command (SET_LOW, SET_HIGH, TOGGLE, PULSE)
//   req_ready_o  : command accepted when valid & ready at a clock edge
//   serial_o     : registered line level
//   r_edge_o     : one-cycle rising-edge strobe
//   f_edge_o     : one-cycle falling-edge strobe
//   busy_o       : FSM not idle
// -----------------------------------------------------------------------------
module wedge_drv
    import wedge_pkg::*;
#(
    parameter int   HOLD_CYCLES = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       req_valid_i,
    input  wedge_cmd_e req_cmd_i,
    output logic       req_ready_o,
    output logic       serial_o,
    output logic       r_edge_o,
    output logic       f_edge_o,
    output logic       busy_o
);

    // Counter load value: the edge cycle itself counts as the first hold cycle.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    wedge_state_e r_state;
    wedge_state_e w_state_next;
    logic         r_serial;
    logic         w_serial_next;
    logic         r_r_edge;
    logic         r_f_edge;
    logic         w_r_edge_next;
    logic         w_f_edge_next;
    logic         w_ready;
    logic         w_accept;
    logic         w_target;
    logic         w_cnt_load;
    logic         w_cnt_en;
    logic         w_cnt_zero;

    wedge_hold_cnt u_hold_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .load_i   (w_cnt_load),
        .value_i  (HOLD_LOAD),
        .enable_i (w_cnt_en),
        .zero_o   (w_cnt_zero)
    );

    assign w_ready  = en_i & (r_state == ST_IDLE) & ~clr_i;
    assign w_accept = req_valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_state  <= ST_IDLE;
            r_serial <= RESET_VAL;
            r_r_edge <= 1'b0;
            r_f_edge <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_serial <= w_serial_next;
            r_r_edge <= w_r_edge_next;
            r_f_edge <= w_f_edge_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_serial_next = r_serial;
        w_cnt_load    = 1'b0;
        w_cnt_en      = 1'b0;
        w_target      = target_level(req_cmd_i, r_serial);

        if (en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (req_cmd_i == PULSE) begin
`ifdef WEDGE_DRV_PULSE_EN
                            w_serial_next = ~r_serial;
                            w_cnt_load    = 1'b1;
                            w_state_next  = ST_PULSE;
`endif
                        end else if (w_target != r_serial) begin
                            w_serial_next = w_target;
                            w_cnt_load    = 1'b1;
                            w_state_next  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_zero) begin
                        w_state_next = ST_IDLE;
                    end
                end
`ifdef WEDGE_DRV_PULSE_EN
                ST_PULSE: begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_zero) begin
                        w_serial_next = ~r_serial;
                        w_cnt_load    = 1'b1;
                        w_state_next  = ST_HOLD;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Strobes are recomputed every cycle, so they never stretch while
        // en_i is low; reset/clear level changes bypass this path entirely.
        w_r_edge_next = w_serial_next & ~r_serial;
        w_f_edge_next = ~w_serial_next & r_serial;
    end

    assign req_ready_o = w_ready;
    assign serial_o    = r_serial;
    assign r_edge_o    = r_r_edge;
    assign f_edge_o    = r_f_edge;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wedge_drv.sv
// -----------------------------------------------------------------------------
// tb_wedge_drv
// Directed bench for wedge_drv (HOLD_CYCLES=3, RESET_VAL=0). Each stimulus
// row drives one cycle of inputs and pushes the outputs expected in that
// cycle, packed as {serial, r_edge, f_edge, busy, ready}; a monitor pops
// and compares on every falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wedge_drv;
    import wedge_pkg::*;

    typedef struct {
        string      name;
        logic [4:0] v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic       req_valid;
    wedge_cmd_e req_cmd;
    logic       req_ready;
    logic       serial;
    logic       r_edge;
    logic       f_edge;
    logic       busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    wedge_drv #(
        .HOLD_CYCLES (3),
        .RESET_VAL   (1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .en_i        (en),
        .req_valid_i (req_valid),
        .req_cmd_i   (req_cmd),
        .req_ready_o (req_ready),
        .serial_o    (serial),
        .r_edge_o    (r_edge),
        .f_edge_o    (f_edge),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the observed outputs against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] got;
            e   = exp_q.pop_front();
            got = {serial, r_edge, f_edge, busy, req_ready};
            n_checks++;
            if (got === e.v) begin
                n_pass++;
                $display("[%0t] %s: sr f b y = %b ok", $time, e.name, got);
            end else begin
                $display("[%0t] FAIL %s: got %b required %b (serial,r_edge,f_edge,busy,ready)",
                         $time, e.name, got, e.v);
            end
        end
    end

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic row(input string nm, input logic i_en, input logic i_clr,
                       input logic i_rst, input logic i_vld, input wedge_cmd_e i_cmd,
                       input logic [4:0] exp_v);
        exp_t e;
        en        = i_en;
        clr       = i_clr;
        rst       = i_rst;
        req_valid = i_vld;
        req_cmd   = i_cmd;
        e.name    = nm;
        e.v       = exp_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        en        = 1'b1;
        req_valid = 1'b0;
        req_cmd   = SET_LOW;
        @(posedge clk);
        #1;

        //   name             en clr rst vld cmd        s r f b y
        row("rst_hold",        1, 0, 1, 0, SET_LOW,  5'b00001);
        row("idle_after_rst",  1, 0, 0, 0, SET_LOW,  5'b00001);
        row("sethi_accept",    1, 0, 0, 1, SET_HIGH, 5'b00001);
        row("sethi_edge",      1, 0, 0, 0, SET_LOW,  5'b11010);
        row("sethi_hold2",     1, 0, 0, 0, SET_LOW,  5'b10010);
        row("sethi_hold3",     1, 0, 0, 0, SET_LOW,  5'b10010);
        row("sethi_same",      1, 0, 0, 1, SET_HIGH, 5'b10001);
        row("tgl_accept",      1, 0, 0, 1, TOGGLE,   5'b10001);
        row("tgl1_fedge",      1, 0, 0, 1, TOGGLE,   5'b00110);
        row("tgl1_hold2",      1, 0, 0, 1, TOGGLE,   5'b00010);
        row("tgl1_hold3",      1, 0, 0, 1, TOGGLE,   5'b00010);
        row("tgl2_accept",     1, 0, 0, 1, TOGGLE,   5'b00001);
        row("tgl2_redge",      1, 0, 0, 1, TOGGLE,   5'b11010);
        row("tgl2_hold2",      1, 0, 0, 1, TOGGLE,   5'b10010);
        row("tgl2_hold3",      1, 0, 0, 1, TOGGLE,   5'b10010);
        row("tgl3_accept",     1, 0, 0, 1, TOGGLE,   5'b10001);
        row("tgl3_fedge",      1, 0, 0, 0, SET_LOW,  5'b00110);
        row("tgl3_hold2",      1, 0, 0, 0, SET_LOW,  5'b00010);
        row("tgl3_hold3",      1, 0, 0, 0, SET_LOW,  5'b00010);
        row("enlo_accept",     1, 0, 0, 1, SET_HIGH, 5'b00001);
        row("enlo_edge",       0, 0, 0, 0, SET_LOW,  5'b11010);
        for (int i = 0; i < 4; i++)
            row("enlo_frozen", 0, 0, 0, 1, SET_LOW,  5'b10010);
        row("enlo_resume1",    1, 0, 0, 0, SET_LOW,  5'b10010);
        row("enlo_resume2",    1, 0, 0, 0, SET_LOW,  5'b10010);
        row("enlo_resume3",    1, 0, 0, 0, SET_LOW,  5'b10010);
        row("setlo_accept",    1, 0, 0, 1, SET_LOW,  5'b10001);
        row("setlo_fedge",     1, 0, 0, 0, SET_LOW,  5'b00110);
        row("setlo_hold2",     1, 0, 0, 0, SET_LOW,  5'b00010);
        row("setlo_hold3",     1, 0, 0, 0, SET_LOW,  5'b00010);
        row("pulse_accept",    1, 0, 0, 1, PULSE,    5'b00001);
`ifdef WEDGE_DRV_PULSE_EN
        row("pulse_redge",     1, 0, 0, 0, SET_LOW,  5'b11010);
        row("pulse_high2",     1, 0, 0, 0, SET_LOW,  5'b10010);
        row("pulse_high3",     1, 0, 0, 0, SET_LOW,  5'b10010);
        row("pulse_fedge",     1, 0, 0, 0, SET_LOW,  5'b00110);
        row("pulse_hold2",     1, 0, 0, 0, SET_LOW,  5'b00010);
        row("pulse_hold3",     1, 0, 0, 0, SET_LOW,  5'b00010);
        row("pclr_accept",     1, 0, 0, 1, PULSE,    5'b00001);
        row("pclr_redge",      1, 0, 0, 0, SET_LOW,  5'b11010);
        row("pclr_clear",      1, 1, 0, 0, SET_LOW,  5'b10010);
`else
        for (int i = 0; i < 6; i++)
            row("pulse_noop",  1, 0, 0, 0, SET_LOW,  5'b00001);
        row("pclr_accept",     1, 0, 0, 1, PULSE,    5'b00001);
        row("pclr_noop",       1, 0, 0, 0, SET_LOW,  5'b00001);
        row("pclr_clear",      1, 1, 0, 0, SET_LOW,  5'b00000);
`endif
        row("clr_over_cmd",    1, 1, 0, 1, SET_HIGH, 5'b00000);
        row("clr_cmd_dropped", 1, 0, 0, 1, SET_HIGH, 5'b00001);
        row("clrhi_clear",     1, 1, 0, 0, SET_LOW,  5'b11010);
        row("clrhi_nofedge",   1, 0, 0, 1, SET_HIGH, 5'b00001);
        row("rsthi_reset",     1, 0, 1, 0, SET_LOW,  5'b11010);
        row("rsthi_nofedge",   1, 0, 0, 0, SET_LOW,  5'b00001);

        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
            $display("[%0t] drain: queue empty ok", $time);
        end else begin
            $display("[%0t] FAIL drain: got %0d pending required 0", $time, exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wedge_drv.md
WEDGE_DRV -- requirements
Module: wedge_drv

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 3, meaning minimum cycles serial_o stays stable after any edge (legal range 1..255).
REQ-002 SHALL have parameter RESET_VAL, default 1'b0, meaning the serial_o level after reset or clear.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port clr_i, input, 1 bit: synchronous clear; aborts the current operation.
REQ-006 SHALL have port en_i, input, 1 bit: advance enable; when low, state, counter and serial_o freeze.
REQ-007 SHALL have port req_valid_i, input, 1 bit: command valid.
REQ-008 SHALL have port req_cmd_i, input, 2 bits, of type wedge_pkg::wedge_cmd_e: SET_LOW=0, SET_HIGH=1, TOGGLE=2, PULSE=3.
REQ-009 SHALL have port req_ready_o, output, 1 bit: command accepted when valid&ready at a clock edge.
REQ-010 SHALL have port serial_o, output, 1 bit: registered line level toward a remote synchronising edge-detector.
REQ-011 SHALL have port r_edge_o, output, 1 bit: one-cycle strobe in the first cycle serial_o shows 1 after a 0.
REQ-012 SHALL have port f_edge_o, output, 1 bit: one-cycle strobe in the first cycle serial_o shows 0 after a 1.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD and PULSE.
REQ-015 SHALL drive req_ready_o = en_i & (state==IDLE) & ~clr_i, combinationally.
REQ-016 In IDLE, an accepted command SHALL compute the target level: SET_LOW->0, SET_HIGH->1, TOGGLE->~serial_o, PULSE->~serial_o.
REQ-017 If the target equals serial_o (non-PULSE), the command SHALL complete with no edge and no strobe, staying in IDLE.
REQ-018 If the target differs, serial_o SHALL take the target at the next edge, with the matching strobe high that same cycle, and the state SHALL move to HOLD with the counter loaded to HOLD_CYCLES-1.
REQ-019 In HOLD, the counter SHALL decrement on each en_i-high cycle; the state SHALL return to IDLE on the edge where the counter is 0 and en_i=1.
REQ-020 Consecutive serial_o edges SHALL be separated by at least HOLD_CYCLES cycles.
REQ-021 PULSE SHALL flip serial_o and enter state PULSE, counting HOLD_CYCLES; it SHALL then flip serial_o back (strobe asserted), load the counter and enter HOLD.
REQ-022 While en_i=0, no state, counter or serial_o change SHALL occur; strobes SHALL still last exactly one cycle.
REQ-023 req_valid_i while req_ready_o=0 SHALL be ignored: no queueing, and the requester holds the command.
REQ-024 With HOLD_CYCLES=1, HOLD SHALL last exactly one cycle.

Reset
REQ-025 rst_i SHALL force serial_o=RESET_VAL, state=IDLE, counter=0 and r_edge_o=f_edge_o=0 at the next edge.
REQ-026 clr_i SHALL have the same effect as rst_i, at lower priority, and SHALL override any same-cycle command.
REQ-027 A serial_o change caused by rst_i or clr_i SHALL NOT raise an edge strobe.

Configuration
REQ-028 Macro WEDGE_DRV_PULSE_EN defined: PULSE SHALL behave as REQ-021.
REQ-029 Macro WEDGE_DRV_PULSE_EN undefined: the PULSE state and its logic SHALL be absent; an accepted PULSE SHALL be consumed as a no-op with no edge.

Structure
REQ-030 Package wedge_pkg SHALL hold wedge_cmd_e, the state enum wedge_state_e and the localparam for counter width ($clog2(256)=8).
REQ-031 The hold down-counter SHALL be one sub-module, wedge_hold_cnt, with ports load, value, enable and zero flag.

Verification
REQ-032 Verification scenario, after reset (HOLD_CYCLES=3, RESET_VAL=0): serial_o=0, busy_o=0 and req_ready_o=1 one cycle after rst_i drops.
REQ-033 Verification scenario, accepted SET_HIGH: serial_o=1 and r_edge_o=1 for one cycle; busy_o=1 for 3 cycles; req_ready_o=0 for 3 cycles.
REQ-034 Verification scenario, back-to-back TOGGLE held valid: edges occur exactly every 4 cycles (1 accept cycle + 3 hold cycles), with alternating r/f strobes.
REQ-035 Verification scenario, PULSE at serial_o=0 with macro defined: 1 for 3 cycles, then 0 with f_edge_o, then busy_o for 3 more cycles; with macro undefined, no change.
REQ-036 Verification scenario, en_i low for 5 cycles mid-HOLD: busy_o is extended by exactly 5 cycles and serial_o stays stable.
REQ-037 Verification scenario, clr_i during PULSE with serial_o=1: serial_o=0 the next cycle, no f_edge_o, state IDLE and req_ready_o=1.
